display_frame_buffer: RTL and testbench

//  64-cell x 2-bit frame store sitting directly upstream of the LED scanner.

---
 rtl/display_frame_buffer.sv | 130 +++++++++++++
 tb/tb_display_frame_buffer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_frame_buffer.sv
// display_frame_buffer
// This module holds the 8x8 board of 2-bit cells that the LED scanner reads.
// Each cell is {red, green}.
// - Game logic writes one cell per cycle through the write port.
// - The scanner reads through a combinational read port.
// - A clear sequencer wipes the board at one cell per cycle.
// - Red and green stone counters are updated on the same edge as the cell.
module display_frame_buffer #(
    parameter int CELLS        = 64,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(CELLS)-1:0]     wr_addr,
    input  logic [1:0]                   wr_data,
    input  logic                         clear_req,
    input  logic [$clog2(CELLS)-1:0]     ram_rd_addr,
    output logic [1:0]                   ram_data,
    output logic                         busy,
    output logic                         wr_rejected,
    output logic [$clog2(CELLS+1)-1:0]   red_count,
    output logic [$clog2(CELLS+1)-1:0]   green_count
);

    localparam int AW = $clog2(CELLS);
    localparam int CW = $clog2(CELLS + 1);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_GREEN = 2'b01;
    localparam logic [1:0] CELL_RED   = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   clear_ptr_q;
    logic [CW-1:0]   red_q;
    logic [CW-1:0]   green_q;
    logic            wr_rejected_q;

    logic [1:0]      mem_q [CELLS];

    logic            wr_accept;
    logic            wr_reject_d;
    logic [1:0]      old_cell;
    logic [CW-1:0]   red_d;
    logic [CW-1:0]   green_d;
    logic            last_cell;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [1:0]      mem_wdata;

    // Decide whether a write is accepted, compute the new counts, and select
    // the single memory write source (clear wins over game writes).
    always_comb begin
        wr_accept   = wr_en && (state_q == ST_IDLE) && !clear_req && (wr_data != CELL_BAD);
        wr_reject_d = wr_en && !wr_accept;
        old_cell    = mem_q[wr_addr];
        // Remove the contribution of the old cell and add the new one.
        // The counts therefore track the board exactly and cannot wrap.
        red_d       = red_q + CW'(wr_data == CELL_RED) - CW'(old_cell == CELL_RED);
        green_d     = green_q + CW'(wr_data == CELL_GREEN) - CW'(old_cell == CELL_GREEN);
        last_cell   = (clear_ptr_q == AW'(CELLS - 1));
        mem_we      = (state_q == ST_CLEAR) || wr_accept;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_data;
        if (state_q == ST_CLEAR) begin
            mem_waddr = clear_ptr_q;
            mem_wdata = CELL_EMPTY;
        end
    end

    // Control FSM: sequences the clear, keeps the stone counts, and flags dropped writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
            clear_ptr_q   <= '0;
            red_q         <= '0;
            green_q       <= '0;
            wr_rejected_q <= 1'b0;
        end else begin
            wr_rejected_q <= wr_reject_d;
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        // The board is about to be wiped, so zero the counts immediately.
                        state_q     <= ST_CLEAR;
                        clear_ptr_q <= '0;
                        red_q       <= '0;
                        green_q     <= '0;
                    end else if (wr_accept) begin
                        red_q   <= red_d;
                        green_q <= green_d;
                    end
                end
                ST_CLEAR: begin
                    // A clear_req that arrives here is ignored; the sequence is not restarted.
                    clear_ptr_q <= clear_ptr_q + 1'b1;
                    if (last_cell) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Cell storage. There is no reset on the array itself.
    // During reset, writes are gated off so the cell contents are left untouched.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // The scanner port reads straight from storage with no latency.
    // A write therefore becomes visible in the cycle after its edge.
    assign ram_data    = mem_q[ram_rd_addr];
    assign busy        = (state_q == ST_CLEAR);
    assign wr_rejected = wr_rejected_q;
    assign red_count   = red_q;
    assign green_count = green_q;

endmodule

// File: tb/tb_display_frame_buffer.sv
// Directed and random bench for display_frame_buffer.
// Inputs change 1 ns after each rising edge, and outputs are sampled there too.
module tb_display_frame_buffer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       clear_req;
    logic [5:0] ram_rd_addr;
    logic [1:0] ram_data;
    logic       busy;
    logic       wr_rejected;
    logic [6:0] red_count;
    logic [6:0] green_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] model [64];

    display_frame_buffer #(
        .CELLS        (64),
        .CLEAR_ON_RST (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .ram_rd_addr (ram_rd_addr),
        .ram_data    (ram_data),
        .busy        (busy),
        .wr_rejected (wr_rejected),
        .red_count   (red_count),
        .green_count (green_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_count(input logic [1:0] v);
        int n = 0;
        for (int i = 0; i < 64; i++) if (model[i] == v) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = 2'b00;
    endtask

    // Drive one write, advance one edge, and update the model if the write should be accepted.
    task automatic do_write(input logic [5:0] a, input logic [1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        if (d != 2'b11) model[a] = d;
    endtask

    // Count the consecutive samples where busy is high.
    // The count starts at the current sample and is bounded at 200.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++;
        if (wr_rejected !== 1'b0 || red_count !== 7'd0 || green_count !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rej=%b red=%0d green=%0d, expected 0/0/0",
                     wr_rejected, red_count, green_count);
        end
        count_busy(n);
        tests_run++;
        if (n != 64) begin
            tests_failed++;
            $display("FAIL reset_busy_len: got %0d cycles, expected 64", n);
        end
        for (int i = 0; i < 64; i++) begin
            ram_rd_addr = 6'(i);
            #1;
            tests_run++;
            if (ram_data !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_cell[%0d]: got %b, expected 00", i, ram_data);
            end
        end
        model_clear();
    endtask

    task automatic test_write_read();
        ram_rd_addr = 6'o05;
        do_write(6'o05, 2'b10);
        tests_run++;
        if (ram_data !== 2'b10 || red_count !== 7'd1 || green_count !== 7'd0) begin
            tests_failed++;
            $display("FAIL write_red: got data=%b red=%0d green=%0d, expected 10/1/0",
                     ram_data, red_count, green_count);
        end
        // There is no bypass, so the old value must still be visible before the edge.
        wr_en = 1'b1; wr_addr = 6'o05; wr_data = 2'b01;
        #1;
        tests_run++;
        if (ram_data !== 2'b10) begin
            tests_failed++;
            $display("FAIL no_bypass: got %b, expected 10", ram_data);
        end
        step();
        wr_en = 1'b0;
        model[5] = 2'b01;
        tests_run++;
        if (ram_data !== 2'b01 || red_count !== 7'd0 || green_count !== 7'd1) begin
            tests_failed++;
            $display("FAIL overwrite_green: got data=%b red=%0d green=%0d, expected 01/0/1",
                     ram_data, red_count, green_count);
        end
        // Rewriting the same value leaves the counts unchanged.
        do_write(6'o05, 2'b01);
        tests_run++;
        if (red_count !== 7'd0 || green_count !== 7'd1) begin
            tests_failed++;
            $display("FAIL same_value: got red=%0d green=%0d, expected 0/1", red_count, green_count);
        end
    endtask

    task automatic test_illegal_write();
        ram_rd_addr = 6'd9;
        do_write(6'd9, 2'b11);
        tests_run++;
        if (wr_rejected !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_reject_pulse: got %b, expected 1", wr_rejected);
        end
        tests_run++;
        if (ram_data !== 2'b00 || red_count !== 7'd0 || green_count !== 7'd1) begin
            tests_failed++;
            $display("FAIL illegal_unchanged: got data=%b red=%0d green=%0d, expected 00/0/1",
                     ram_data, red_count, green_count);
        end
        step();
        tests_run++;
        if (wr_rejected !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_pulse_width: got %b, expected 0", wr_rejected);
        end
    endtask

    task automatic test_clear_collision();
        int n;
        do_write(6'o05, 2'b00);
        for (int i = 0; i < 10; i++) do_write(6'(10 + i), 2'b10);
        for (int i = 0; i < 7; i++) do_write(6'(30 + i), 2'b01);
        tests_run++;
        if (red_count !== 7'd10 || green_count !== 7'd7) begin
            tests_failed++;
            $display("FAIL fill_counts: got red=%0d green=%0d, expected 10/7", red_count, green_count);
        end
        clear_req = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 2'b10;
        step();
        clear_req = 1'b0;
        wr_en = 1'b0;
        tests_run++;
        if (wr_rejected !== 1'b1 || red_count !== 7'd0 || green_count !== 7'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_entry: got rej=%b red=%0d green=%0d busy=%b, expected 1/0/0/1",
                     wr_rejected, red_count, green_count, busy);
        end
        count_busy(n);
        tests_run++;
        if (n != 64) begin
            tests_failed++;
            $display("FAIL clear_busy_len: got %0d cycles, expected 64", n);
        end
        for (int i = 0; i < 64; i++) begin
            ram_rd_addr = 6'(i);
            #1;
            tests_run++;
            if (ram_data !== 2'b00) begin
                tests_failed++;
                $display("FAIL clear_cell[%0d]: got %b, expected 00", i, ram_data);
            end
        end
        model_clear();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        do_write(6'd40, 2'b10);
        do_write(6'd3, 2'b01);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 30; i++) step();
        // clear_ptr is now 30. Cells below it have been wiped; the rest still hold their old data.
        ram_rd_addr = 6'd40;
        #1;
        tests_run++;
        if (ram_data !== 2'b10 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_clear_upper: got data=%b busy=%b, expected 10/1", ram_data, busy);
        end
        ram_rd_addr = 6'd3;
        #1;
        tests_run++;
        if (ram_data !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_clear_lower: got %b, expected 00", ram_data);
        end
        // A clear_req during CLEAR must not restart the sequence.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy(n);
        tests_run++;
        if (n != 64) begin
            tests_failed++;
            $display("FAIL reset_mid_clear_len: got %0d cycles, expected 64", n);
        end
        ram_rd_addr = 6'd40;
        #1;
        tests_run++;
        if (ram_data !== 2'b00 || red_count !== 7'd0 || green_count !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear_after: got data=%b red=%0d green=%0d, expected 00/0/0",
                     ram_data, red_count, green_count);
        end
        model_clear();
    endtask

    task automatic test_random();
        logic [5:0] a;
        logic [5:0] rd;
        logic [1:0] d;
        logic       en;
        for (int it = 0; it < 2000; it++) begin
            a  = 6'($urandom_range(0, 63));
            rd = 6'($urandom_range(0, 63));
            d  = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            wr_en = en; wr_addr = a; wr_data = d;
            step();
            wr_en = 1'b0;
            if (en && d != 2'b11) model[a] = d;
            tests_run++;
            if (red_count !== 7'(model_count(2'b10)) || green_count !== 7'(model_count(2'b01))) begin
                tests_failed++;
                $display("FAIL rand_counts it=%0d: got red=%0d green=%0d, expected %0d/%0d",
                         it, red_count, green_count, model_count(2'b10), model_count(2'b01));
            end
            tests_run++;
            if (wr_rejected !== (en && d == 2'b11)) begin
                tests_failed++;
                $display("FAIL rand_reject it=%0d: got %b, expected %b", it, wr_rejected, en && d == 2'b11);
            end
            ram_rd_addr = a;
            #1;
            tests_run++;
            if (ram_data !== model[a]) begin
                tests_failed++;
                $display("FAIL rand_wr_readback it=%0d addr=%0d: got %b, expected %b", it, a, ram_data, model[a]);
            end
            ram_rd_addr = rd;
            #1;
            tests_run++;
            if (ram_data !== model[rd]) begin
                tests_failed++;
                $display("FAIL rand_readback it=%0d addr=%0d: got %b, expected %b", it, rd, ram_data, model[rd]);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        clear_req   = 1'b0;
        ram_rd_addr = '0;
        test_reset();
        test_write_read();
        test_illegal_write();
        test_clear_collision();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
